seg_scan_mux: RTL and testbench

Parametrised time-multiplexed driver for common-anode/common-cathode multi-digit seven-segment displays. It scans N_DIGITS pre-decoded segment patterns onto one shared segment bus and a one-hot digit-select bus. Beyond basic scanning, it adds:
- a programmable scan prescaler,
- anti-ghosting dead time at every digit switch,
- 16-level PWM brightness,
- per-digit enable.

It sits between the per-digit segment decoders and the board pins.

---
 rtl/seg_scan_mux_pkg.sv | 23 ++
 rtl/seg_scan_mux_timer.sv | 36 +++
 rtl/seg_scan_mux.sv | 88 ++++++++
 tb/tb_seg_scan_mux.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_mux_pkg.sv
// Shared constants and polarity helpers for the seven-segment scan driver.
package seg_pkg;

  localparam int unsigned BRIGHT_W   = 4;
  localparam int unsigned BRIGHT_MAX = 15;
  localparam int unsigned MAX_SEG_W  = 32;
  localparam int unsigned MAX_DIGITS = 16;
  localparam int unsigned MAX_IDX_W  = 4;

  // Inactive segment pattern, wide enough for any SEG_W; callers truncate.
  function automatic logic [MAX_SEG_W-1:0] seg_blank(input logic active_low);
    return {MAX_SEG_W{active_low}};
  endfunction

  // One-hot digit select in pin polarity; callers truncate to N_DIGITS.
  function automatic logic [MAX_DIGITS-1:0] anode_onehot(input logic [MAX_IDX_W-1:0] idx,
                                                         input logic active_low);
    logic [MAX_DIGITS-1:0] oh;
    oh = MAX_DIGITS'(1) << idx;
    return active_low ? ~oh : oh;
  endfunction

endpackage

// File: rtl/seg_scan_mux_timer.sv
// Slot counter and digit index for the scan; flags slot and frame starts.
module seg_scan_timer #(
  parameter int unsigned N_DIGITS = 4,
  parameter int unsigned PRESCALE = 100000,
  localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1,
  localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] slot_cnt,
  output logic [IDX_W-1:0] idx,
  output logic             slot_start,
  output logic             frame_start
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt <= '0;
      idx      <= '0;
    end else if (slot_cnt == CNT_LAST) begin
      slot_cnt <= '0;
      idx      <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
    end else begin
      slot_cnt <= slot_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    slot_start  = (slot_cnt == '0);
    frame_start = (slot_cnt == '0) && (idx == '0);
  end

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed seven-segment driver: per-slot sampling, dead time,
// 16-level PWM brightness and per-digit enable onto registered pins.
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int unsigned N_DIGITS         = 4,
  parameter int unsigned SEG_W            = 8,
  parameter int unsigned PRESCALE         = 100000,
  parameter int unsigned DEAD             = 16,
  parameter bit          ANODE_ACTIVE_LOW = 1'b1,
  parameter bit          SEG_ACTIVE_LOW   = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_DIGITS*SEG_W-1:0] seg_in,
  input  logic [N_DIGITS-1:0]       digit_en,
  input  logic [BRIGHT_W-1:0]       brightness,
  output logic [SEG_W-1:0]          seg_out,
  output logic [N_DIGITS-1:0]       anode,
  output logic                      frame_tick
);

  localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int unsigned STEP  = (PRESCALE - DEAD) / BRIGHT_MAX;

  localparam logic [SEG_W-1:0]    SEG_OFF   = SEG_W'(seg_blank(SEG_ACTIVE_LOW));
  localparam logic [N_DIGITS-1:0] ANODE_OFF = N_DIGITS'(seg_blank(ANODE_ACTIVE_LOW));

  logic [CNT_W-1:0]    slot_cnt;
  logic [IDX_W-1:0]    idx;
  logic                slot_start;
  logic                frame_start;

  logic [BRIGHT_W-1:0] bri_q;
  logic [SEG_W-1:0]    pat_q;
  logic                en_q;
  logic [31:0]         limit_c;
  logic                lit_c;

  seg_scan_timer #(
    .N_DIGITS (N_DIGITS),
    .PRESCALE (PRESCALE)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .slot_cnt    (slot_cnt),
    .idx         (idx),
    .slot_start  (slot_start),
    .frame_start (frame_start)
  );

  // Slot-start sampling: mid-slot input changes wait for the next slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      bri_q <= '0;
      pat_q <= '0;
      en_q  <= 1'b0;
    end else if (slot_start) begin
      bri_q <= brightness;
      pat_q <= seg_in[32'(idx)*SEG_W +: SEG_W];
      en_q  <= digit_en[idx];
    end
  end

  // Slot cycle 0 is always dark: the samples for the new digit land only at
  // its end, so this also guarantees a one-cycle gap when DEAD is zero.
  always_comb begin
    limit_c = 32'(DEAD) + 32'(bri_q) * 32'(STEP);
    lit_c   = 1'b0;
    if ((slot_cnt != '0) && (32'(slot_cnt) >= 32'(DEAD)) && en_q && (bri_q != '0)) begin
      lit_c = (bri_q == BRIGHT_W'(BRIGHT_MAX)) || (32'(slot_cnt) < limit_c);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      anode      <= ANODE_OFF;
      seg_out    <= SEG_OFF;
      frame_tick <= 1'b0;
    end else begin
      anode      <= lit_c ? N_DIGITS'(anode_onehot(MAX_IDX_W'(idx), ANODE_ACTIVE_LOW)) : ANODE_OFF;
      seg_out    <= lit_c ? pat_q : SEG_OFF;
      frame_tick <= frame_start;
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux: directed scenario tasks plus a cycle scoreboard.
module tb_seg_scan_mux;

  localparam int N    = 4;
  localparam int W    = 8;
  localparam int PRE  = 32;
  localparam int DEAD = 2;
  localparam int STEP = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  seg_in = 32'h0011_2233;
  logic [3:0]   digit_en = 4'hF;
  logic [3:0]   brightness = 4'd15;
  logic [7:0]   seg_out;
  logic [3:0]   anode;
  logic         frame_tick;

  int n_tests = 0;
  int n_fail  = 0;

  logic [12:0] exp_q[$];

  seg_scan_mux #(
    .N_DIGITS         (N),
    .SEG_W            (W),
    .PRESCALE         (PRE),
    .DEAD             (DEAD),
    .ANODE_ACTIVE_LOW (1'b1),
    .SEG_ACTIVE_LOW   (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .seg_in     (seg_in),
    .digit_en   (digit_en),
    .brightness (brightness),
    .seg_out    (seg_out),
    .anode      (anode),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  // Reference model: position in the frame derived from cycles since reset.
  int unsigned m_t = 0;
  logic [3:0]  m_bri = '0;
  logic [7:0]  m_pat = '0;
  logic        m_en  = 1'b0;
  always @(posedge clk) begin
    int pos, dig;
    logic on;
    logic [3:0] ea;
    logic [7:0] es;
    logic eft;
    if (rst) begin
      m_t = 0; m_bri = '0; m_pat = '0; m_en = 1'b0;
      ea = 4'hF; es = 8'hFF; eft = 1'b0;
    end else begin
      pos = int'(m_t % PRE);
      dig = int'((m_t / PRE) % N);
      if (pos == 0) begin
        m_bri = brightness;
        m_pat = seg_in[dig*W +: W];
        m_en  = digit_en[dig];
      end
      on  = (pos >= DEAD) && m_en && (m_bri != 0) &&
            ((m_bri == 15) || (pos < DEAD + int'(m_bri) * STEP));
      ea  = on ? ~(4'b0001 << dig) : 4'hF;
      es  = on ? m_pat : 8'hFF;
      eft = (m_t % (N * PRE)) == 0;
      m_t = m_t + 1;
    end
    exp_q.push_back({ea, es, eft});
  end

  // Scoreboard compare plus exclusivity and dead-time monitors.
  int dark_run = 0;
  int last_dig = -1;
  always @(posedge clk) begin
    logic [12:0] e;
    int d;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if ({anode, seg_out, frame_tick} !== e) begin
        n_fail++;
        $display("FAIL scoreboard t=%0t got anode=%b seg=%h ft=%b exp anode=%b seg=%h ft=%b",
                 $time, anode, seg_out, frame_tick, e[12:9], e[8:1], e[0]);
      end
    end
    n_tests++;
    if ($countones(~anode) > 1) begin
      n_fail++;
      $display("FAIL onehot t=%0t anode=%b exp at most one low bit", $time, anode);
    end
    if (anode === 4'hF) begin
      dark_run++;
    end else begin
      d = 0;
      for (int i = 0; i < N; i++) if (anode[i] == 1'b0) d = i;
      if (last_dig >= 0 && d != last_dig) begin
        n_tests++;
        if (dark_run < DEAD) begin
          n_fail++;
          $display("FAIL deadtime t=%0t dark=%0d exp>=%0d", $time, dark_run, DEAD);
        end
      end
      last_dig = d;
      dark_run = 0;
    end
  end

  function automatic logic [3:0] sel_pat(input int d);
    case (d)
      0: return 4'b1110;
      1: return 4'b1101;
      2: return 4'b1011;
      default: return 4'b0111;
    endcase
  endfunction

  function automatic logic [7:0] seg_pat(input int d);
    case (d)
      0: return 8'h33;
      1: return 8'h22;
      2: return 8'h11;
      default: return 8'h00;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic restart();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_tests++;
    if (anode !== 4'hF) begin n_fail++; $display("FAIL reset_anode got %b exp 1111", anode); end
    n_tests++;
    if (seg_out !== 8'hFF) begin n_fail++; $display("FAIL reset_seg got %h exp ff", seg_out); end
    n_tests++;
    if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL reset_ft got %b exp 0", frame_tick); end
  endtask

  task automatic test_full_scan();
    int pos, d;
    logic [3:0] ea;
    logic [7:0] es;
    brightness = 4'd15; digit_en = 4'hF; seg_in = 32'h0011_2233;
    restart();
    for (int k = 1; k <= 129; k++) begin
      tick();
      pos = (k - 1) % PRE;
      d   = ((k - 1) / PRE) % N;
      ea  = (pos >= 2) ? sel_pat(d) : 4'hF;
      es  = (pos >= 2) ? seg_pat(d) : 8'hFF;
      n_tests++;
      if (anode !== ea || seg_out !== es) begin
        n_fail++;
        $display("FAIL full_scan k=%0d got %b/%h exp %b/%h", k, anode, seg_out, ea, es);
      end
      n_tests++;
      if (frame_tick !== ((k - 1) % 128 == 0)) begin
        n_fail++;
        $display("FAIL full_scan_ft k=%0d got %b", k, frame_tick);
      end
    end
  endtask

  task automatic test_brightness();
    int pos, d, lit_cnt;
    logic [3:0] ea;
    brightness = 4'd4; digit_en = 4'hF;
    restart();
    lit_cnt = 0;
    for (int k = 1; k <= 128; k++) begin
      tick();
      pos = (k - 1) % PRE;
      d   = ((k - 1) / PRE) % N;
      ea  = (pos >= 2 && pos < 10) ? sel_pat(d) : 4'hF;
      if (anode !== 4'hF) lit_cnt++;
      n_tests++;
      if (anode !== ea) begin
        n_fail++;
        $display("FAIL bri4 k=%0d got %b exp %b", k, anode, ea);
      end
    end
    n_tests++;
    if (lit_cnt != 32) begin n_fail++; $display("FAIL bri4_count got %0d exp 32", lit_cnt); end
    brightness = 4'd0;
    restart();
    for (int k = 1; k <= 128; k++) begin
      tick();
      n_tests++;
      if (anode !== 4'hF || seg_out !== 8'hFF) begin
        n_fail++;
        $display("FAIL bri0 k=%0d got %b/%h exp 1111/ff", k, anode, seg_out);
      end
    end
  endtask

  task automatic test_digit_en();
    int pos, d;
    logic [3:0] ea;
    brightness = 4'd15; digit_en = 4'b1011;
    restart();
    for (int k = 1; k <= 129; k++) begin
      tick();
      pos = (k - 1) % PRE;
      d   = ((k - 1) / PRE) % N;
      ea  = (pos >= 2 && d != 2) ? sel_pat(d) : 4'hF;
      n_tests++;
      if (anode !== ea) begin
        n_fail++;
        $display("FAIL digit_en k=%0d got %b exp %b", k, anode, ea);
      end
      if (k == 1 || k == 129) begin
        n_tests++;
        if (frame_tick !== 1'b1) begin n_fail++; $display("FAIL digit_en_ft k=%0d got 0 exp 1", k); end
      end
    end
    digit_en = 4'hF;
  endtask

  task automatic test_bri_change();
    int pos, d;
    logic on;
    logic [3:0] ea;
    brightness = 4'd15; digit_en = 4'hF;
    restart();
    for (int k = 1; k <= 64; k++) begin
      tick();
      if (k == 10) brightness = 4'd1;
      pos = (k - 1) % PRE;
      d   = ((k - 1) / PRE) % N;
      on  = (d == 0) ? (pos >= 2) : (pos >= 2 && pos < 4);
      ea  = on ? sel_pat(d) : 4'hF;
      n_tests++;
      if (anode !== ea) begin
        n_fail++;
        $display("FAIL bri_change k=%0d got %b exp %b", k, anode, ea);
      end
    end
    brightness = 4'd15;
  endtask

  task automatic test_mid_reset();
    logic [3:0] ea;
    brightness = 4'd15; digit_en = 4'hF; seg_in = 32'h0011_2233;
    restart();
    repeat (84) tick();
    n_tests++;
    if (anode !== 4'b1011) begin n_fail++; $display("FAIL mid_pre got %b exp 1011", anode); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++;
    if (anode !== 4'hF || seg_out !== 8'hFF || frame_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset got %b/%h/%b exp 1111/ff/0", anode, seg_out, frame_tick);
    end
    for (int k = 1; k <= 33; k++) begin
      tick();
      ea = (k >= 3 && k <= 32) ? 4'b1110 : 4'hF;
      n_tests++;
      if (anode !== ea || frame_tick !== (k == 1)) begin
        n_fail++;
        $display("FAIL mid_restart k=%0d got %b/%b exp %b/%b", k, anode, frame_tick, ea, k == 1);
      end
    end
  endtask

  task automatic test_random();
    restart();
    for (int k = 0; k < 1500; k++) begin
      tick();
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 7) == 0) brightness = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) seg_in = $urandom;
      if ($urandom_range(0, 19) == 0) digit_en = 4'($urandom_range(0, 15));
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_scan();
    test_brightness();
    test_digit_en();
    test_bri_change();
    test_mid_reset();
    test_random();
    tick();
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
